// File: rtl/bitfuscnn_pkg.sv
// Shared types and constants for the bitfuscnn tile sequencer.
package bitfuscnn_pkg;

    localparam int LANES      = 4;
    localparam int PIPE_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_LAND,
        ST_ISSUE,
        ST_DRAIN,
        ST_XFER,
        ST_WAIT_PPU,
        ST_DONE
    } seq_state_t;

    // Number of LANES-wide groups needed to hold n elements.
    function automatic logic [7:0] ceil_div4(input logic [7:0] n);
        logic [8:0] sum;
        sum = {1'b0, n} + 9'd3;
        return {1'b0, sum[8:2]};
    endfunction

endpackage

// File: rtl/bitfuscnn_lane_mask.sv
// Marks which of the LANES entries of a group hold real elements of a count.
module bitfuscnn_lane_mask
    import bitfuscnn_pkg::*;
(
    input  logic [7:0] count,
    input  logic [7:0] group_idx,
    output logic [3:0] mask
);

    logic [9:0] base;

    assign base = {group_idx, 2'b00};

    always_comb begin
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = ({2'b00, count} > (base + 10'(i)));
        end
    end

endmodule

// File: rtl/bitfuscnn_tile_sequencer.sv
// Loop-nest controller for one PE tile: RAM fetch, operand issue, drain,
// buffer swap and PPU handshake, frozen by crossbar stall.
module bitfuscnn_tile_sequencer
    import bitfuscnn_pkg::*;
#(
    parameter int RAM_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           weight_count,
    input  logic [7:0]           activation_count,
    input  logic [7:0]           channel_groups,
    input  logic [RAM_WIDTH-1:0] weight_base,
    input  logic [RAM_WIDTH-1:0] act_base,
    input  logic                 cxb_stall,
    input  logic                 ppu_done,
    output logic                 ram_read,
    output logic [RAM_WIDTH-1:0] w_addr,
    output logic [RAM_WIDTH-1:0] a_addr,
    output logic                 w_load,
    output logic                 a_load,
    output logic                 mult_valid,
    output logic [3:0]           w_lane_valid,
    output logic [3:0]           a_lane_valid,
    output logic                 transfer,
    output logic                 busy,
    output logic                 done
);

    seq_state_t           state_q, state_d;
    logic [1:0]           beat_q, beat_d;
    logic [7:0]           drain_q, drain_d;
    logic [7:0]           wg_q, wg_d, ag_q, ag_d, cg_q, cg_d;
    logic [7:0]           wc_q, wc_d, ac_q, ac_d, cgroups_q, cgroups_d;
    logic [RAM_WIDTH-1:0] w_ptr_q, w_ptr_d, a_cg_ptr_q, a_cg_ptr_d;

    logic                 ram_read_q, ram_read_d;
    logic [RAM_WIDTH-1:0] w_addr_q, w_addr_d, a_addr_q, a_addr_d;
    logic                 w_load_q, w_load_d, a_load_q, a_load_d;
    logic                 mult_valid_q, mult_valid_d;
    logic [3:0]           w_lane_q, w_lane_d, a_lane_q, a_lane_d;
    logic                 transfer_q, transfer_d, busy_q, busy_d, done_q, done_d;

    logic [7:0]           nw, na;
    logic [3:0]           w_mask, a_mask;
    logic                 stalled;

    assign nw = ceil_div4(wc_q);
    assign na = ceil_div4(ac_q);

    // Stall suppresses new reads/issues in the cycle it is seen; loads owed
    // to an earlier read are unaffected.
    assign stalled    = cxb_stall && (state_q inside {ST_FILL, ST_LAND, ST_ISSUE, ST_DRAIN});
    assign ram_read   = ram_read_q && !cxb_stall;
    assign mult_valid = mult_valid_q && !cxb_stall;

    bitfuscnn_lane_mask u_w_mask (
        .count     (wc_d),
        .group_idx (wg_d),
        .mask      (w_mask)
    );

    bitfuscnn_lane_mask u_a_mask (
        .count     (ac_d),
        .group_idx (ag_d),
        .mask      (a_mask)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        wg_d       = wg_q;
        ag_d       = ag_q;
        cg_d       = cg_q;
        wc_d       = wc_q;
        ac_d       = ac_q;
        cgroups_d  = cgroups_q;
        w_ptr_d    = w_ptr_q;
        a_cg_ptr_d = a_cg_ptr_q;

        if (abort) begin
            state_d    = ST_IDLE;
            beat_d     = '0;
            drain_d    = '0;
            wg_d       = '0;
            ag_d       = '0;
            cg_d       = '0;
            w_ptr_d    = '0;
            a_cg_ptr_d = '0;
        end else if (!stalled) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        wc_d       = weight_count;
                        ac_d       = activation_count;
                        cgroups_d  = channel_groups;
                        beat_d     = '0;
                        drain_d    = '0;
                        wg_d       = '0;
                        ag_d       = '0;
                        cg_d       = '0;
                        w_ptr_d    = weight_base;
                        a_cg_ptr_d = act_base;
                        if (channel_groups == 8'd0)
                            state_d = ST_DONE;
                        else if (weight_count == 8'd0 || activation_count == 8'd0)
                            state_d = ST_DRAIN;
                        else
                            state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (beat_q == 2'd3) begin
                        beat_d  = '0;
                        state_d = ST_LAND;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
                ST_LAND: state_d = ST_ISSUE;
                ST_ISSUE: begin
                    if (ag_q + 8'd1 < na) begin
                        ag_d    = ag_q + 8'd1;
                        state_d = ST_FILL;
                    end else begin
                        ag_d    = '0;
                        w_ptr_d = w_ptr_q + RAM_WIDTH'(LANES);
                        if (wg_q + 8'd1 < nw) begin
                            wg_d    = wg_q + 8'd1;
                            state_d = ST_FILL;
                        end else begin
                            drain_d = '0;
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 8'(PIPE_DEPTH - 1)) begin
                        drain_d = '0;
                        state_d = ST_XFER;
                    end else begin
                        drain_d = drain_q + 8'd1;
                    end
                end
                ST_XFER: state_d = ST_WAIT_PPU;
                ST_WAIT_PPU: begin
                    if (ppu_done) begin
                        if (cg_q + 8'd1 < cgroups_q) begin
                            cg_d       = cg_q + 8'd1;
                            a_cg_ptr_d = a_cg_ptr_q + RAM_WIDTH'({na, 2'b00});
                            wc_d       = weight_count;
                            ac_d       = activation_count;
                            cgroups_d  = channel_groups;
                            wg_d       = '0;
                            ag_d       = '0;
                            beat_d     = '0;
                            drain_d    = '0;
                            if (weight_count == 8'd0 || activation_count == 8'd0)
                                state_d = ST_DRAIN;
                            else
                                state_d = ST_FILL;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they appear registered.
        ram_read_d   = (state_d == ST_FILL);
        w_addr_d     = ram_read_d ? (w_ptr_d + RAM_WIDTH'(beat_d)) : '0;
        a_addr_d     = ram_read_d ? (a_cg_ptr_d + RAM_WIDTH'({ag_d, 2'b00}) + RAM_WIDTH'(beat_d)) : '0;
        w_load_d     = ram_read && (ag_q == 8'd0) && !abort;
        a_load_d     = ram_read && !abort;
        mult_valid_d = (state_d == ST_ISSUE);
        w_lane_d     = mult_valid_d ? w_mask : 4'b0000;
        a_lane_d     = mult_valid_d ? a_mask : 4'b0000;
        transfer_d   = (state_d == ST_XFER);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            drain_q      <= '0;
            wg_q         <= '0;
            ag_q         <= '0;
            cg_q         <= '0;
            wc_q         <= '0;
            ac_q         <= '0;
            cgroups_q    <= '0;
            w_ptr_q      <= '0;
            a_cg_ptr_q   <= '0;
            ram_read_q   <= 1'b0;
            w_addr_q     <= '0;
            a_addr_q     <= '0;
            w_load_q     <= 1'b0;
            a_load_q     <= 1'b0;
            mult_valid_q <= 1'b0;
            w_lane_q     <= '0;
            a_lane_q     <= '0;
            transfer_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            drain_q      <= drain_d;
            wg_q         <= wg_d;
            ag_q         <= ag_d;
            cg_q         <= cg_d;
            wc_q         <= wc_d;
            ac_q         <= ac_d;
            cgroups_q    <= cgroups_d;
            w_ptr_q      <= w_ptr_d;
            a_cg_ptr_q   <= a_cg_ptr_d;
            ram_read_q   <= ram_read_d;
            w_addr_q     <= w_addr_d;
            a_addr_q     <= a_addr_d;
            w_load_q     <= w_load_d;
            a_load_q     <= a_load_d;
            mult_valid_q <= mult_valid_d;
            w_lane_q     <= w_lane_d;
            a_lane_q     <= a_lane_d;
            transfer_q   <= transfer_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign w_addr       = w_addr_q;
    assign a_addr       = a_addr_q;
    assign w_load       = w_load_q;
    assign a_load       = a_load_q;
    assign w_lane_valid = w_lane_q;
    assign a_lane_valid = a_lane_q;
    assign transfer     = transfer_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_bitfuscnn_tile_sequencer.sv
// Directed job table for the tile sequencer plus a mid-job reset sequence.
module tb_bitfuscnn_tile_sequencer;

    localparam int RAM_WIDTH  = 14;
    localparam int RUN_CYCLES = 50;
    localparam int PPU_DELAY  = 3;
    localparam int NUM_VECS   = 8;

    logic                 clk = 1'b0;
    logic                 reset_n, start, abort, cxb_stall, ppu_done;
    logic [7:0]           weight_count, activation_count, channel_groups;
    logic [RAM_WIDTH-1:0] weight_base, act_base, w_addr, a_addr;
    logic                 ram_read, w_load, a_load, mult_valid, transfer, busy, done;
    logic [3:0]           w_lane_valid, a_lane_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int wc, ac, cg, stall_from, stall_to, abort_t;
        int exp_reads, exp_first_mult, exp_mults, exp_xfers, exp_first_xfer;
        int exp_done, exp_busy_low, exp_wloads, exp_aloads;
        int exp_wlane0, exp_wlane1, exp_alane0, exp_alane1;
        int a_idx, exp_a_addr, exp_last_w;
    } vec_t;

    typedef struct {
        int reads, first_mult, mults, xfers, first_xfer, done_t, busy_low;
        int wloads, aloads, wlane0, wlane1, alane0, alane1, a_addr, last_w, zero_vec;
    } res_t;

    vec_t vecs [NUM_VECS];

    always #5 clk = ~clk;

    bitfuscnn_tile_sequencer #(.RAM_WIDTH(RAM_WIDTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .weight_count     (weight_count),
        .activation_count (activation_count),
        .channel_groups   (channel_groups),
        .weight_base      (weight_base),
        .act_base         (act_base),
        .cxb_stall        (cxb_stall),
        .ppu_done         (ppu_done),
        .ram_read         (ram_read),
        .w_addr           (w_addr),
        .a_addr           (a_addr),
        .w_load           (w_load),
        .a_load           (a_load),
        .mult_valid       (mult_valid),
        .w_lane_valid     (w_lane_valid),
        .a_lane_valid     (a_lane_valid),
        .transfer         (transfer),
        .busy             (busy),
        .done             (done)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Runs one job from cycle t0 (start) at a negedge; ppu_done answers each transfer.
    task automatic applyStimulus(input vec_t v, output res_t r);
        int ppu_t;
        r = '{default: 0};
        r.first_mult = -1;
        r.first_xfer = -1;
        r.done_t     = -1;
        r.busy_low   = -1;
        ppu_t = -100;
        weight_count     = 8'(v.wc);
        activation_count = 8'(v.ac);
        channel_groups   = 8'(v.cg);
        for (int t = 0; t < RUN_CYCLES; t++) begin
            start     = (t == 0);
            cxb_stall = (t >= v.stall_from) && (t <= v.stall_to);
            abort     = (t == v.abort_t);
            ppu_done  = (t == ppu_t);
            #1;
            if (ram_read) begin
                if (r.reads == v.a_idx) r.a_addr = int'(a_addr);
                r.last_w = int'(w_addr);
                r.reads++;
            end
            if (mult_valid) begin
                if (r.mults == 0) begin
                    r.wlane0 = int'(w_lane_valid);
                    r.alane0 = int'(a_lane_valid);
                    r.first_mult = t;
                end else if (r.mults == 1) begin
                    r.wlane1 = int'(w_lane_valid);
                    r.alane1 = int'(a_lane_valid);
                end
                r.mults++;
            end
            if (transfer) begin
                if (r.xfers == 0) r.first_xfer = t;
                r.xfers++;
                ppu_t = t + PPU_DELAY;
            end
            if (done && r.done_t < 0) r.done_t = t;
            if (t >= 1 && !busy && r.busy_low < 0) r.busy_low = t;
            if (w_load) r.wloads++;
            if (a_load) r.aloads++;
            if (t == v.abort_t + 1)
                r.zero_vec = int'({ram_read, w_load, a_load, mult_valid, transfer, busy, done,
                                   |w_addr, |a_addr, |w_lane_valid, |a_lane_valid});
            @(negedge clk);
        end
        start     = 1'b0;
        abort     = 1'b0;
        cxb_stall = 1'b0;
        ppu_done  = 1'b0;
    endtask

    initial begin
        res_t r;
        string p;

        vecs[0] = '{4, 8, 1, -1, -1, -1, 8, 6, 2, 1, 17, 21, 22, 4, 8, 15, 15, 15, 15, 4, 'h204, 'h103};
        vecs[1] = '{6, 3, 1, -1, -1, -1, 8, 6, 2, 1, 17, 21, 22, 8, 8, 15, 3, 7, 7, 4, 'h200, 'h107};
        vecs[2] = '{4, 8, 1, 3, 5, -1, 8, 9, 2, 1, 20, 24, 25, 4, 8, 15, 15, 15, 15, 4, 'h204, 'h103};
        vecs[3] = '{4, 8, 2, -1, -1, -1, 16, 6, 4, 2, 17, 41, 42, 8, 16, 15, 15, 15, 15, 8, 'h208, 'h107};
        vecs[4] = '{4, 8, 1, -1, -1, 8, 6, 6, 1, 0, -1, -1, 9, 4, 5, 15, 0, 15, 0, 4, 'h204, 'h101};
        vecs[5] = '{4, 8, 0, -1, -1, -1, 0, -1, 0, 0, -1, 1, 2, 0, 0, 0, 0, 0, 0, -1, 0, 0};
        vecs[6] = '{0, 8, 1, -1, -1, -1, 0, -1, 0, 1, 5, 9, 10, 0, 0, 0, 0, 0, 0, -1, 0, 0};
        vecs[7] = vecs[0];

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; cxb_stall = 1'b0; ppu_done = 1'b0;
        weight_count = 8'd0; activation_count = 8'd0; channel_groups = 8'd0;
        weight_base = 14'h100; act_base = 14'h200;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset outputs", int'({ram_read, w_load, a_load, mult_valid, transfer, done,
                                          w_addr, a_addr, w_lane_valid, a_lane_valid}), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], r);
            p = $sformatf("v%0d", i);
            checkOutput({p, " reads"},      r.reads,      vecs[i].exp_reads);
            checkOutput({p, " first_mult"}, r.first_mult, vecs[i].exp_first_mult);
            checkOutput({p, " mults"},      r.mults,      vecs[i].exp_mults);
            checkOutput({p, " xfers"},      r.xfers,      vecs[i].exp_xfers);
            checkOutput({p, " first_xfer"}, r.first_xfer, vecs[i].exp_first_xfer);
            checkOutput({p, " done_t"},     r.done_t,     vecs[i].exp_done);
            checkOutput({p, " busy_low"},   r.busy_low,   vecs[i].exp_busy_low);
            checkOutput({p, " w_loads"},    r.wloads,     vecs[i].exp_wloads);
            checkOutput({p, " a_loads"},    r.aloads,     vecs[i].exp_aloads);
            checkOutput({p, " w_lane0"},    r.wlane0,     vecs[i].exp_wlane0);
            checkOutput({p, " w_lane1"},    r.wlane1,     vecs[i].exp_wlane1);
            checkOutput({p, " a_lane0"},    r.alane0,     vecs[i].exp_alane0);
            checkOutput({p, " a_lane1"},    r.alane1,     vecs[i].exp_alane1);
            checkOutput({p, " last_w"},     r.last_w,     vecs[i].exp_last_w);
            checkOutput({p, " idle_zero"},  r.zero_vec,   0);
            if (vecs[i].a_idx >= 0)
                checkOutput({p, " a_addr"}, r.a_addr,     vecs[i].exp_a_addr);
        end

        // Reset asserted in the middle of a job clears outputs without a clock edge.
        weight_count = 8'd4; activation_count = 8'd8; channel_groups = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midjob ram_read before reset", int'(ram_read), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midjob busy after reset", int'(busy), 0);
        checkOutput("midjob ram_read after reset", int'(ram_read), 0);
        checkOutput("midjob a_addr after reset", int'(a_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midjob stays idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
